// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of pwm_in, converts duty to an
// 8-bit code with a sequential restoring divider, and flags a missing signal.
module pwm_capture #(
    parameter  int CLK_FREQUENCY = 450_000_000,
    localparam int TIMEOUT       = 2 * (CLK_FREQUENCY / 1_000),
    localparam int CW            = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pwm_in,
    output logic [7:0]    duty_cycle,
    output logic [1:0]    freq_select,
    output logic [CW-1:0] period_cnt,
    output logic [CW-1:0] high_cnt,
    output logic          valid,
    output logic          no_signal
);

    localparam int P1K   = CLK_FREQUENCY / 1_000;
    localparam int P10K  = CLK_FREQUENCY / 10_000;
    localparam int P50K  = CLK_FREQUENCY / 50_000;
    localparam int P100K = CLK_FREQUENCY / 100_000;

    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TH_1K  = CW'((P1K + P10K) / 2);
    localparam logic [CW-1:0] TH_10K = CW'((P10K + P50K) / 2);
    localparam logic [CW-1:0] TH_50K = CW'((P50K + P100K) / 2);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state, state_next;
    logic          s1, s2, s2_d;
    logic          rise, fall;
    logic [CW-1:0] cnt, hi_tmp;
    logic          latch_hi, complete, timeout;

    logic          div_busy;
    logic [2:0]    div_step;
    logic [CW-1:0] div_hi, per_tmp, rem, rem_next;
    logic [6:0]    quo;
    logic [CW:0]   shifted;
    logic          qbit;

    function automatic logic [1:0] freq_of(input logic [CW-1:0] p);
        if (p > TH_1K)       return 2'b00;
        else if (p > TH_10K) return 2'b01;
        else if (p > TH_50K) return 2'b10;
        else                 return 2'b11;
    endfunction

    assign rise = s2 & ~s2_d;
    assign fall = ~s2 & s2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s2_d  <= 1'b0;
            state <= IDLE;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            s2_d  <= s2;
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        latch_hi   = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: if (rise) state_next = HIGH;
            HIGH: begin
                if (fall) begin
                    latch_hi   = 1'b1;
                    state_next = LOW;
                end else if (cnt == T_MAX) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            LOW: begin
                if (rise) begin
                    complete   = 1'b1;
                    state_next = HIGH;
                end else if (cnt == T_MAX) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: remainder stays below per_tmp, so CW bits suffice.
    always_comb begin
        shifted  = {rem, 1'b0};
        qbit     = (shifted >= {1'b0, per_tmp});
        rem_next = qbit ? CW'(shifted - {1'b0, per_tmp}) : shifted[CW-1:0];
    end

    // The divider keeps its own copy of the high time because hi_tmp may be
    // overwritten by the next fall while a conversion is still running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            hi_tmp      <= '0;
            div_busy    <= 1'b0;
            div_step    <= '0;
            div_hi      <= '0;
            per_tmp     <= '0;
            rem         <= '0;
            quo         <= '0;
            duty_cycle  <= '0;
            freq_select <= '0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            valid       <= 1'b0;
            no_signal   <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (rise)              cnt <= CW'(1);
            else if (cnt != T_MAX) cnt <= cnt + 1'b1;

            if (latch_hi) hi_tmp <= cnt;

            if (timeout) begin
                duty_cycle <= s2 ? 8'hFF : 8'h00;
                period_cnt <= '0;
                high_cnt   <= '0;
                valid      <= 1'b1;
                no_signal  <= 1'b1;
                div_busy   <= 1'b0;
            end else if (div_busy) begin
                rem <= rem_next;
                quo <= {quo[5:0], qbit};
                if (div_step == 3'd7) begin
                    duty_cycle  <= {quo, qbit};
                    period_cnt  <= per_tmp;
                    high_cnt    <= div_hi;
                    freq_select <= freq_of(per_tmp);
                    valid       <= 1'b1;
                    no_signal   <= 1'b0;
                    div_busy    <= 1'b0;
                end else begin
                    div_step <= div_step + 1'b1;
                end
            end else if (complete) begin
                div_hi   <= hi_tmp;
                per_tmp  <= cnt;
                rem      <= hi_tmp;
                quo      <= '0;
                div_step <= '0;
                div_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture at a reduced clock rate so timeouts stay short.
module tb_pwm_capture;

    localparam int CLK_FREQUENCY = 2_000_000;
    localparam int P1K     = CLK_FREQUENCY / 1_000;
    localparam int P10K    = CLK_FREQUENCY / 10_000;
    localparam int P50K    = CLK_FREQUENCY / 50_000;
    localparam int P100K   = CLK_FREQUENCY / 100_000;
    localparam int TIMEOUT = 2 * P1K;
    localparam int CW      = $clog2(TIMEOUT + 1);

    typedef struct {
        int duty;
        int freq;
        int per;
        int hi;
        int nosig;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pwm_in = 1'b0;
    logic [7:0]    duty_cycle;
    logic [1:0]    freq_select;
    logic [CW-1:0] period_cnt, high_cnt;
    logic          valid, no_signal;

    pwm_capture #(.CLK_FREQUENCY(CLK_FREQUENCY)) dut (
        .clk(clk), .reset(reset), .pwm_in(pwm_in),
        .duty_cycle(duty_cycle), .freq_select(freq_select),
        .period_cnt(period_cnt), .high_cnt(high_cnt),
        .valid(valid), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   cyc = 0;

    // Reference model state
    bit   armed = 0;
    bit   have_accept = 0;
    int   last_accept = 0;
    int   prev_h = 0, prev_l = 0;
    int   last_freq = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_freq(input int p);
        if (p > (P1K + P10K) / 2)        return 0;
        else if (p > (P10K + P50K) / 2)  return 1;
        else if (p > (P50K + P100K) / 2) return 2;
        else                             return 3;
    endfunction

    // A rise completes the previous measurement unless the divider is still busy.
    task automatic start_rise();
        exp_t e;
        if (armed && (!have_accept || (cyc - last_accept) >= 9)) begin
            e.per   = prev_h + prev_l;
            e.hi    = prev_h;
            e.duty  = (prev_h * 256) / e.per;
            e.freq  = model_freq(e.per);
            e.nosig = 0;
            last_freq   = e.freq;
            last_accept = cyc;
            have_accept = 1;
            q.push_back(e);
        end
        armed = 1;
    endtask

    task automatic drive_period(input int h, input int l);
        start_rise();
        prev_h = h;
        prev_l = l;
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic expect_timeout(input int level);
        exp_t e;
        e.duty  = level ? 255 : 0;
        e.freq  = last_freq;
        e.per   = 0;
        e.hi    = 0;
        e.nosig = 1;
        q.push_back(e);
        armed       = 0;
        have_accept = 0;
        repeat (TIMEOUT + 20) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("duty_cycle",  int'(duty_cycle),  e.duty);
                check("freq_select", int'(freq_select), e.freq);
                check("period_cnt",  int'(period_cnt),  e.per);
                check("high_cnt",    int'(high_cnt),    e.hi);
                check("no_signal",   int'(no_signal),   e.nosig);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_duty",      int'(duty_cycle),  0);
        check("rst_freq",      int'(freq_select), 0);
        check("rst_period",    int'(period_cnt),  0);
        check("rst_high",      int'(high_cnt),    0);
        check("rst_valid",     int'(valid),       0);
        check("rst_no_signal", int'(no_signal),   0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        repeat (3) drive_period(1000, 1000);
        repeat (4) drive_period(5, 15);
        repeat (2) drive_period(299, 1);
        repeat (2) drive_period(1, 299);
        repeat (3) drive_period(4, 5);
        repeat (3) drive_period(4, 4);
        drive_period(50, 150);
        repeat (5) drive_period(2, 2);
        repeat (2) drive_period(50, 150);

        // Stuck low after a 10 kHz-class stream
        repeat (2) drive_period(50, 150);
        expect_timeout(0);
        check("no_signal_set", int'(no_signal), 1);

        repeat (3) drive_period(5, 15);

        // Stuck high
        start_rise();
        pwm_in = 1'b1;
        expect_timeout(1);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);

        repeat (3) drive_period(5, 15);
        repeat (30) @(negedge clk);
        check("queue_drained_before_reset", q.size(), 0);

        // Reset in the middle of a conversion
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_duty",   int'(duty_cycle),  0);
        check("midrst_freq",   int'(freq_select), 0);
        check("midrst_period", int'(period_cnt),  0);
        check("midrst_high",   int'(high_cnt),    0);
        check("midrst_valid",  int'(valid),       0);
        armed = 0; have_accept = 0; last_freq = 0;
        repeat (3) @(negedge clk);
        pwm_in = 1'b0;
        reset  = 1'b0;
        repeat (3) @(negedge clk);

        repeat (3) drive_period(5, 15);
        start_rise();
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        check("pending_expected", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform, the receive-side counterpart of the team's `pwm_generator`. It recovers period, high time, the 8-bit duty code (0–255 scale) and the nearest of the four standard frequency selections. It sits between an external PWM pin and control logic that needs to read back or loop-check PWM settings. Duty is computed by a sequential 8-iteration divider, so measurement of the next period continues while the current one is converted.

## Interface
- `CLK_FREQUENCY`, 450_000_000: clock rate in Hz.
- Derived: `P1K=CLK_FREQUENCY/1_000`, `P10K=/10_000`, `P50K=/50_000`, `P100K=/100_000`, `TIMEOUT=2*P1K`, `CW=$clog2(TIMEOUT+1)` (20 at default).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty_cycle`  out  8  floor(high_cnt*256/period_cnt); 0 after reset.
- `freq_select`  out  2  nearest standard frequency (00=1 kHz, 01=10 kHz, 10=50 kHz, 11=100 kHz); 00 after reset.
- `period_cnt`  out  CW  last measured period in clk cycles; 0 after reset.
- `high_cnt`  out  CW  last measured high time in clk cycles; 0 after reset.
- `valid`  out  1  one-cycle pulse when the outputs above update; 0 after reset.
- `no_signal`  out  1  set on timeout, cleared by the next valid measurement; 0 after reset.

## Operation
- Input path: 2-flop synchronizer, then a delayed copy. `rise = s2 & ~s2_d`, `fall = ~s2 & s2_d`.
- Counter `cnt` (CW bits):
  - loads 1 on `rise`;
  - otherwise increments every cycle;
  - saturates at TIMEOUT.
- FSM states IDLE, HIGH, LOW:
  - IDLE: ignores `fall`. On `rise` goes to HIGH and loads cnt.
  - HIGH: on `fall`, latches `hi_tmp=cnt` and goes to LOW. If cnt==TIMEOUT, takes the timeout action.
  - LOW: on `rise`, the measurement is complete: `per_tmp=cnt` and the next measurement starts in HIGH. If cnt==TIMEOUT, takes the timeout action.
- Resulting widths for a synced signal high H cycles and low L cycles: `high=H`, `period=H+L`.
- On completion, if the divider is idle, it loads (hi_tmp, per_tmp).
  - If the divider is busy, the measurement is discarded: no `valid`, and the FSM continues normally.
- Divider: restoring, 1 quotient bit per cycle, 8 cycles, dividend hi_tmp<<8.
  - Because hi_tmp ≤ per_tmp−1, the quotient is always ≤ 255, so no clamp is needed.
- On divider finish, all four outputs register together, `valid` pulses and `no_signal` clears:
  - `duty_cycle` = quotient;
  - `period_cnt` = per_tmp;
  - `high_cnt` = hi_tmp;
  - `freq_select` from period_cnt:
    - `> (P1K+P10K)/2` gives 00;
    - else `> (P10K+P50K)/2` gives 01;
    - else `> (P50K+P100K)/2` gives 10;
    - else 11.
  - At the default clock these thresholds are 247500, 27000 and 6750.
- Timeout action (no edge for TIMEOUT cycles in HIGH or LOW):
  - `duty_cycle` = s2 ? 255 : 0;
  - `period_cnt` = `high_cnt` = 0;
  - `freq_select` holds its value;
  - `valid` pulses, `no_signal` = 1, FSM goes to IDLE.
- Reset mid-measurement or mid-division: everything aborts immediately with no `valid`. The first `rise` after reset only arms the FSM; the first `valid` follows the second `rise`.

## Timing
- Edge 0 is the first clock edge that samples `pwm_in` high.
  - `rise` is true in the cycle after edge 1.
  - `per_tmp` and divider operands latch at edge 2.
  - Divider iterates at edges 3–10.
  - Outputs and `valid` register at edge 10; `valid` is high for exactly one cycle.
- Completion-to-valid latency: 9 cycles. Completions closer than 9 cycles apart are dropped.
- Timeout `valid` and `no_signal` register one edge after cnt reaches TIMEOUT.
- Outputs hold between `valid` pulses.

## Test plan
- 1 kHz, 50% (high 225000, low 225000 cycles) → second and later `valid`: period_cnt=450000, high_cnt=225000, duty_cycle=128, freq_select=00.
- 100 kHz, high 1125 / low 3375 → period_cnt=4500, duty_cycle=64, freq_select=11, `valid` once per 4500 cycles.
- Extreme duty: high 4499 / low 1 → duty_cycle=255; high 1 / low 4499 → duty_cycle=0; freq_select=11 in both cases.
- Input stuck low after a 10 kHz stream → after 900000 cycles: `valid` pulse, no_signal=1, duty_cycle=0, period_cnt=0, freq_select stays 01. A later stream clears no_signal on its first measurement.
- Burst of 2-cycle-high / 2-cycle-low pulses between normal periods → dropped measurements produce no `valid`. The next measurement separated by ≥9 cycles reports correct values.
- `reset` asserted mid-division → all outputs 0 at once and no `valid`. After release, the first rise produces no `valid`; the second produces a correct one.
